color_meas_ctrl: RTL and testbench

COLOR_MEAS_CTRL -- requirements
Module: color_meas_ctrl

---
 rtl/color_pkg.sv | 58 +++++
 rtl/edge_window_counter.sv | 63 ++++++
 rtl/color_meas_ctrl.sv | 175 +++++++++++++++++
 tb/tb_color_meas_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// color_pkg
// Shared definitions for the TCS3200 colour measurement controller:
//   state_t    - controller FSM states
//   chan_t     - measurement channel index, in measurement order
//   FILT_*     - sensor S2/S3 filter select codes
//   SCALE_*    - sensor S0/S1 output frequency scaling codes
//   chanCode   - maps a channel index to its S2/S3 filter code
//   nextChan   - next channel in the RED, GREEN, BLUE, CLEAR sequence
package color_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    CLEAR = 2'd3
  } chan_t;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_IDLE  = 2'b00;

  localparam logic [1:0] SCALE_OFF   = 2'b00;
  localparam logic [1:0] SCALE_20PCT = 2'b10;

  function automatic logic [1:0] chanCode(input chan_t ch);
    logic [1:0] code;
    case (ch)
      RED:     code = FILT_RED;
      GREEN:   code = FILT_GREEN;
      BLUE:    code = FILT_BLUE;
      CLEAR:   code = FILT_CLEAR;
      default: code = FILT_CLEAR;
    endcase
    return code;
  endfunction

  // CLEAR is terminal; the FSM leaves for DONE instead of advancing past it.
  function automatic chan_t nextChan(input chan_t ch);
    chan_t nxt;
    case (ch)
      RED:     nxt = GREEN;
      GREEN:   nxt = BLUE;
      BLUE:    nxt = CLEAR;
      default: nxt = CLEAR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/edge_window_counter.sv
// edge_window_counter
// Brings the asynchronous sensor frequency output into the clk domain, detects
// its rising edges and counts them with a saturating counter.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   sensor_in  in   asynchronous sensor frequency output
//   clear      in   force the count to zero (takes priority over enable)
//   enable     in   count detected edges while high
//   count      out  value the counter holds after this clock edge, i.e. the
//                   registered count including an edge detected this cycle
module edge_window_counter #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic [CNT_W-1:0] w_countNext;

  // r_sync1/r_sync2 are the metastability filter; r_sync3 is the delayed copy
  // used only for edge detection.
  assign w_rise = r_sync2 & ~r_sync3;

  // Exposing the next value lets the controller capture the final window cycle
  // in the same edge that ends the window.
  always_comb begin
    w_countNext = r_count;
    if (clear) begin
      w_countNext = '0;
    end else if (enable && w_rise && (r_count != CNT_MAX)) begin
      w_countNext = r_count + CNT_W'(1);
    end
  end

  assign count = w_countNext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_count <= w_countNext;
    end
  end

endmodule

// File: rtl/color_meas_ctrl.sv
// color_meas_ctrl
// Arbitrates between two requesters and runs a TCS3200 colour measurement:
// for each channel the filter is switched, allowed to settle, then sensor
// edges are counted over a fixed window and latched into a result register.
// Ports:
//   clk                     in   system clock, rising edge
//   rst                     in   synchronous reset, active-low
//   req[1:0]                in   level request per requester, held until ack
//   mode[1:0]               in   per requester: 0 = clear only, 1 = R/G/B/clear
//   sensor_out              in   asynchronous sensor frequency output
//   ack[1:0]                out  one-cycle pulse to the granted requester
//   busy                    out  high from grant through the ack cycle
//   s2_s3[1:0]              out  sensor filter select
//   s0_s1[1:0]              out  sensor frequency scaling
//   oe_n                    out  sensor output enable, active-low
//   red/green/blue/clear_cnt out latched edge counts per channel
module color_meas_ctrl
  import color_pkg::*;
#(
  parameter int WIN_CYCLES    = 5000000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       mode,
  input  logic             sensor_out,
  output logic [1:0]       ack,
  output logic             busy,
  output logic [1:0]       s2_s3,
  output logic [1:0]       s0_s1,
  output logic             oe_n,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt
);

  localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  chan_t            r_chan;
  logic [TMR_W-1:0] r_timer;
  logic [1:0]       r_grant;
  logic             r_lastGrant;
  logic [CNT_W-1:0] r_redCnt;
  logic [CNT_W-1:0] r_greenCnt;
  logic [CNT_W-1:0] r_blueCnt;
  logic [CNT_W-1:0] r_clearCnt;

  logic             w_pick;
  logic             w_grantNow;
  logic             w_countDone;
  logic             w_counterClear;
  logic             w_counterEnable;
  logic             w_active;
  logic [CNT_W-1:0] w_count;

  edge_window_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .sensor_in (sensor_out),
    .clear     (w_counterClear),
    .enable    (w_counterEnable),
    .count     (w_count)
  );

  // Round-robin: r_lastGrant resets to 1 so the first contest goes to
  // requester 0; a lone request always wins.
  always_comb begin
    w_pick = 1'b0;
    case (req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_lastGrant;
      default: w_pick = 1'b0;
    endcase
  end

  // The counter is held clear throughout SETTLE so COUNT always starts from
  // zero and edges seen while the filter settles are discarded.
  always_comb begin
    w_nextState     = r_state;
    w_grantNow      = 1'b0;
    w_countDone     = 1'b0;
    w_counterClear  = 1'b0;
    w_counterEnable = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_grantNow  = 1'b1;
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        w_counterClear = 1'b1;
        if (r_timer == SETTLE_LAST) begin
          w_nextState = COUNT;
        end
      end
      COUNT: begin
        w_counterEnable = 1'b1;
        if (r_timer == WIN_LAST) begin
          w_countDone = 1'b1;
          w_nextState = (r_chan == CLEAR) ? DONE : SETTLE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_active  = (r_state != IDLE);
  assign busy      = w_active;
  assign ack       = (r_state == DONE) ? r_grant : 2'b00;
  assign s2_s3     = w_active ? chanCode(r_chan) : FILT_IDLE;
  assign s0_s1     = w_active ? SCALE_20PCT : SCALE_OFF;
  assign oe_n      = ~w_active;
  assign red_cnt   = r_redCnt;
  assign green_cnt = r_greenCnt;
  assign blue_cnt  = r_blueCnt;
  assign clear_cnt = r_clearCnt;

  // The timer restarts on every state change so each SETTLE and COUNT phase
  // runs for exactly its programmed number of cycles. Clear-only requests
  // start at CLEAR, which leaves the R/G/B registers untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_chan      <= RED;
      r_grant     <= 2'b00;
      r_lastGrant <= 1'b1;
      r_redCnt    <= '0;
      r_greenCnt  <= '0;
      r_blueCnt   <= '0;
      r_clearCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || (r_state == IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_grantNow) begin
        r_grant     <= w_pick ? 2'b10 : 2'b01;
        r_lastGrant <= w_pick;
        r_chan      <= mode[w_pick] ? RED : CLEAR;
      end
      if (w_countDone) begin
        case (r_chan)
          RED:     r_redCnt   <= w_count;
          GREEN:   r_greenCnt <= w_count;
          BLUE:    r_blueCnt  <= w_count;
          default: r_clearCnt <= w_count;
        endcase
        if (r_chan != CLEAR) begin
          r_chan <= nextChan(r_chan);
        end
      end
    end
  end

endmodule

// File: tb/tb_color_meas_ctrl.sv
// tb_color_meas_ctrl
// Self-checking bench for color_meas_ctrl with WIN_CYCLES=100, SETTLE_CYCLES=4.
// A second instance with CNT_W=5 and a fast sensor exercises saturation.
module tb_color_meas_ctrl;

  localparam int WIN  = 100;
  localparam int SET  = 4;
  localparam int CW   = 8;
  localparam int CW2  = 5;
  localparam int SLOT = WIN + SET;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    mode = 2'b00;
  logic          sensorOut = 1'b0;
  logic [1:0]    ack;
  logic          busy;
  logic [1:0]    s2s3;
  logic [1:0]    s0s1;
  logic          oeN;
  logic [CW-1:0] redCnt, greenCnt, blueCnt, clearCnt;

  logic           [1:0] req2 = 2'b00;
  logic           [1:0] mode2 = 2'b00;
  logic                 fastSensor = 1'b0;
  logic           [1:0] ack2;
  logic                 busy2;
  logic           [1:0] s2s3B;
  logic           [1:0] s0s1B;
  logic                 oeNB;
  logic [CW2-1:0] redCnt2, greenCnt2, blueCnt2, clearCnt2;

  int   sensPeriod = 10;
  logic sensLevel = 1'b0;
  int   checks = 0;
  int   errors = 0;

  color_meas_ctrl #(.WIN_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .sensor_out(sensorOut),
    .ack(ack), .busy(busy), .s2_s3(s2s3), .s0_s1(s0s1), .oe_n(oeN),
    .red_cnt(redCnt), .green_cnt(greenCnt), .blue_cnt(blueCnt), .clear_cnt(clearCnt)
  );

  color_meas_ctrl #(.WIN_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(CW2)) dutSat (
    .clk(clk), .rst(rst), .req(req2), .mode(mode2), .sensor_out(fastSensor),
    .ack(ack2), .busy(busy2), .s2_s3(s2s3B), .s0_s1(s0s1B), .oe_n(oeNB),
    .red_cnt(redCnt2), .green_cnt(greenCnt2), .blue_cnt(blueCnt2), .clear_cnt(clearCnt2)
  );

  always #5 clk = ~clk;

  // Sensor model: square wave of sensPeriod clk cycles, or a static level
  // (sensLevel) when sensPeriod is 0.
  always begin
    if (sensPeriod == 0) begin
      @(negedge clk);
      sensorOut = sensLevel;
    end else begin
      repeat (sensPeriod / 2) @(negedge clk);
      sensorOut = ~sensorOut;
    end
  end

  // Two-cycle period square wave for the saturation instance.
  always @(negedge clk) fastSensor = ~fastSensor;

  typedef struct {
    logic [1:0] reqBits;
    logic [1:0] modeBits;
    int         period;
    bit         fullMode;
    logic [1:0] expAck;
    int         expLat;
    int         cntLo;
    int         cntHi;
  } vec_t;

  vec_t vecs[5];
  logic [1:0] chanCodes[4];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if ((act < lo) || (act > hi)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ack"}, ack, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " s2_s3"}, s2s3, 0);
    checkOutput({tag, " s0_s1"}, s0s1, 0);
    checkOutput({tag, " oe_n"}, oeN, 1);
    checkOutput({tag, " red_cnt"}, redCnt, 0);
    checkOutput({tag, " green_cnt"}, greenCnt, 0);
    checkOutput({tag, " blue_cnt"}, blueCnt, 0);
    checkOutput({tag, " clear_cnt"}, clearCnt, 0);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] m);
    req  = r;
    mode = m;
  endtask

  // Returns at the first negedge with busy high, i.e. the cycle after the grant edge.
  task automatic waitGrant(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s grant timeout: got busy 0 expected 1", tag);
  endtask

  // Called in cycle 1 after the grant edge; returns in the ack cycle with its
  // cycle number, checking the channel filter code in each SETTLE phase.
  task automatic waitAck(input string tag, input bit fullMode, output int lat, output logic [1:0] ackSeen);
    lat = 1;
    ackSeen = 2'b00;
    while (lat <= 600) begin
      if (lat == 2) begin
        checkOutput({tag, " s0_s1 active"}, s0s1, 2);
        checkOutput({tag, " oe_n active"}, oeN, 0);
      end
      for (int k = 0; k < 4; k++) begin
        if (lat == k * SLOT + 2) begin
          if (fullMode) checkOutput($sformatf("%s s2_s3 ch%0d", tag, k), s2s3, chanCodes[k]);
          else if (k == 0) checkOutput({tag, " s2_s3 clear only"}, s2s3, 2'b10);
        end
      end
      if (ack != 2'b00) begin
        ackSeen = ack;
        return;
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s ack timeout: got no ack expected ack within 600 cycles", tag);
  endtask

  initial begin
    int            lat;
    logic [1:0]    a;
    logic [CW-1:0] sR, sG, sB;
    int            badAck;
    bit            ok;

    chanCodes[0] = 2'b00;
    chanCodes[1] = 2'b11;
    chanCodes[2] = 2'b01;
    chanCodes[3] = 2'b10;
    vecs[0] = '{2'b01, 2'b01, 10, 1'b1, 2'b01, 417, 9, 11};
    vecs[1] = '{2'b10, 2'b00, 10, 1'b0, 2'b10, 105, 9, 11};
    vecs[2] = '{2'b01, 2'b00, 20, 1'b0, 2'b01, 105, 4, 6};
    vecs[3] = '{2'b10, 2'b10, 4,  1'b1, 2'b10, 417, 24, 26};
    vecs[4] = '{2'b01, 2'b10, 0,  1'b0, 2'b01, 105, 0, 0};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(negedge clk);

    // Both requesters held, clear-only: grants alternate 0,1,0,1
    applyStimulus(2'b11, 2'b00);
    for (int g = 0; g < 4; g++) begin
      waitGrant("rr");
      waitAck($sformatf("rr%0d", g), 1'b0, lat, a);
      checkOutput($sformatf("rr%0d ack", g), a, (g % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rr%0d latency", g), lat, 105);
      checkOutput($sformatf("rr%0d busy in ack", g), busy, 1);
      checkRange($sformatf("rr%0d clear_cnt", g), clearCnt, 9, 11);
      checkOutput($sformatf("rr%0d red held", g), redCnt, 0);
      checkOutput($sformatf("rr%0d green held", g), greenCnt, 0);
      checkOutput($sformatf("rr%0d blue held", g), blueCnt, 0);
    end
    applyStimulus(2'b00, 2'b00);
    repeat (2) @(negedge clk);
    checkOutput("idle busy", busy, 0);
    checkOutput("idle s0_s1", s0s1, 0);
    checkOutput("idle oe_n", oeN, 1);

    // Table of single measurements
    for (int i = 0; i < 5; i++) begin
      sensPeriod = vecs[i].period;
      sensLevel  = 1'b0;
      repeat (20) @(negedge clk);
      sR = redCnt;
      sG = greenCnt;
      sB = blueCnt;
      applyStimulus(vecs[i].reqBits, vecs[i].modeBits);
      waitGrant($sformatf("vec%0d", i));
      waitAck($sformatf("vec%0d", i), vecs[i].fullMode, lat, a);
      checkOutput($sformatf("vec%0d ack", i), a, vecs[i].expAck);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      checkRange($sformatf("vec%0d clear_cnt", i), clearCnt, vecs[i].cntLo, vecs[i].cntHi);
      if (vecs[i].fullMode) begin
        checkRange($sformatf("vec%0d red_cnt", i), redCnt, vecs[i].cntLo, vecs[i].cntHi);
        checkRange($sformatf("vec%0d green_cnt", i), greenCnt, vecs[i].cntLo, vecs[i].cntHi);
        checkRange($sformatf("vec%0d blue_cnt", i), blueCnt, vecs[i].cntLo, vecs[i].cntHi);
      end else begin
        checkOutput($sformatf("vec%0d red held", i), redCnt, sR);
        checkOutput($sformatf("vec%0d green held", i), greenCnt, sG);
        checkOutput($sformatf("vec%0d blue held", i), blueCnt, sB);
      end
      applyStimulus(2'b00, 2'b00);
      @(negedge clk);
      checkOutput($sformatf("vec%0d busy after ack", i), busy, 0);
      checkOutput($sformatf("vec%0d oe_n after ack", i), oeN, 1);
    end

    // Request dropped after grant; one sensor edge only inside SETTLE
    sensPeriod = 0;
    sensLevel  = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(2'b01, 2'b00);
    sensLevel = 1'b1;
    waitGrant("drop");
    applyStimulus(2'b00, 2'b00);
    waitAck("drop", 1'b0, lat, a);
    checkOutput("drop ack", a, 2'b01);
    checkOutput("drop latency", lat, 105);
    checkOutput("drop settle edge ignored", clearCnt, 0);
    repeat (2) @(negedge clk);

    // Reset in cycle 200 of a full measurement
    sensPeriod = 10;
    repeat (20) @(negedge clk);
    applyStimulus(2'b01, 2'b01);
    waitGrant("rst");
    badAck = 0;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (ack != 2'b00) badAck++;
    end
    rst = 1'b0;
    applyStimulus(2'b00, 2'b00);
    @(negedge clk);
    checkResetValues("midreset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) badAck++;
    end
    checkOutput("midreset no ack", badAck, 0);
    applyStimulus(2'b11, 2'b11);
    waitGrant("restart");
    checkOutput("restart s2_s3 red", s2s3, 2'b00);
    waitAck("restart", 1'b1, lat, a);
    checkOutput("restart ack first contest", a, 2'b01);
    checkOutput("restart latency", lat, 417);
    applyStimulus(2'b00, 2'b00);
    repeat (2) @(negedge clk);

    // Saturation on the CNT_W=5 instance
    req2  = 2'b01;
    mode2 = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (busy2) ok = 1'b1;
    end
    checkOutput("sat grant", ok, 1);
    checkOutput("sat s2_s3", s2s3B, 2'b10);
    checkOutput("sat s0_s1", s0s1B, 2'b10);
    checkOutput("sat oe_n", oeNB, 0);
    lat = 1;
    while (ack2 == 2'b00 && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("sat ack", ack2, 2'b01);
    checkOutput("sat latency", lat, 105);
    checkOutput("sat clear_cnt", clearCnt2, 31);
    checkOutput("sat red held", redCnt2, 0);
    checkOutput("sat green held", greenCnt2, 0);
    checkOutput("sat blue held", blueCnt2, 0);
    req2 = 2'b00;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
